// File: rtl/tomasulo_pkg.sv
// Shared types and helpers for the Tomasulo completion path.
// Holds the default tag width, FP word width, the CDB entry layout and the zero test.
package tomasulo_pkg;

  localparam int TAG_W_DEF = 4;
  localparam int FP_W      = 32;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [FP_W-1:0]      data;
  } cdb_entry_t;

  // Exponent field of zero is treated as zero; denormals are flushed.
  function automatic logic exp_is_zero(input logic [FP_W-1:0] v);
    return v[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// Synchronous result FIFO for completed FU ops awaiting the CDB.
// Only pointers and occupancy are reset; storage holds whatever was last written.
module fu_result_fifo
  import tomasulo_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cdb_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_cdb_stage.sv
// Completion stage behind the FP magnitude adder: aligns tag/sign with the adder
// result, substitutes zero-operand results, buffers and broadcasts on the CDB.
module fpadd_cdb_stage
  import tomasulo_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fu_valid,
  output logic             fu_ready,
  input  logic [TAG_W-1:0] fu_tag,
  input  logic [31:0]      fu_a,
  input  logic [31:0]      fu_b,
  output logic [30:0]      add_in1,
  output logic [30:0]      add_in2,
  input  logic [30:0]      add_result,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [FP_W-1:0]  data;
  } entry_t;

  logic            issue_p0;
  logic            a_zero_p0;
  logic            b_zero_p0;
  logic            byp_p0;
  logic [FP_W-1:0] bval_p0;

  logic             vld_p  [1:ADD_LAT];
  logic [TAG_W-1:0] tag_p  [1:ADD_LAT];
  logic             sign_p [1:ADD_LAT];
  logic             byp_p  [1:ADD_LAT];
  logic [FP_W-1:0]  bval_p [1:ADD_LAT];

  logic [AW:0]   inflight;
  logic [AW:0]   occ;
  logic [AW+1:0] used;
  logic          full;
  logic          empty;
  entry_t        push_entry;
  entry_t        head_entry;

  assign add_in1 = fu_a[30:0];
  assign add_in2 = fu_b[30:0];

  // Stage p0: issue handshake and zero-bypass decision.
  always_comb begin
    issue_p0  = fu_valid && fu_ready;
    a_zero_p0 = exp_is_zero(fu_a);
    b_zero_p0 = exp_is_zero(fu_b);
    byp_p0    = a_zero_p0 || b_zero_p0;
    if (a_zero_p0 && b_zero_p0) bval_p0 = {fu_a[31], 31'b0};
    else if (a_zero_p0)         bval_p0 = fu_b;
    else                        bval_p0 = fu_a;
  end

  // Stages p1..pADD_LAT: track each op alongside the adder's internal pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= ADD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[1] <= issue_p0;
      for (int i = 2; i <= ADD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[1]  <= fu_tag;
    sign_p[1] <= fu_a[31];
    byp_p[1]  <= byp_p0;
    bval_p[1] <= bval_p0;
    for (int i = 2; i <= ADD_LAT; i++) begin
      tag_p[i]  <= tag_p[i-1];
      sign_p[i] <= sign_p[i-1];
      byp_p[i]  <= byp_p[i-1];
      bval_p[i] <= bval_p[i-1];
    end
  end

  // Final stage: adder result lands and is merged with the op's sign.
  always_comb begin
    push_entry.tag  = tag_p[ADD_LAT];
    push_entry.data = byp_p[ADD_LAT] ? bval_p[ADD_LAT] : {sign_p[ADD_LAT], add_result};
  end

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= ADD_LAT; i++) inflight = inflight + (AW+1)'(vld_p[i]);
  end

  // Credits cover ops still inside the adder so a landing result always has a slot.
  assign used     = {1'b0, occ} + {1'b0, inflight};
  assign fu_ready = !rst && !full && (used < DEPTH_W);

  fu_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p[ADD_LAT]),
    .din   (push_entry),
    .pop   (cdb_grant),
    .head  (head_entry),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign cdb_req  = !empty;
  assign cdb_tag  = empty ? '0 : head_entry.tag;
  assign cdb_data = empty ? '0 : head_entry.data;

endmodule

// File: tb/tb_fpadd_cdb_stage.sv
// Bench for fpadd_cdb_stage: behavioural adder, queue-based result model,
// directed scenarios with literal expectations and a randomized order/wrap run.
module tb_fpadd_cdb_stage;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             fu_valid;
  logic             fu_ready;
  logic [TAG_W-1:0] fu_tag;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [30:0]      add_in1;
  logic [30:0]      add_in2;
  logic [30:0]      add_result;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  fpadd_cdb_stage #(.TAG_W(TAG_W), .DEPTH(DEPTH), .ADD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .fu_valid   (fu_valid),
    .fu_ready   (fu_ready),
    .fu_tag     (fu_tag),
    .fu_a       (fu_a),
    .fu_b       (fu_b),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_result (add_result),
    .cdb_req    (cdb_req),
    .cdb_grant  (cdb_grant),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Same-sign magnitude add of normals, truncating; exponent wrap passes through.
  function automatic logic [30:0] fp_mag_add(input logic [30:0] x, input logic [30:0] y);
    logic [7:0]  ex, ey, e, d;
    logic [24:0] mx, my, s;
    if (x[30:23] >= y[30:23]) begin
      ex = x[30:23]; ey = y[30:23]; mx = {2'b01, x[22:0]}; my = {2'b01, y[22:0]};
    end else begin
      ex = y[30:23]; ey = x[30:23]; mx = {2'b01, y[22:0]}; my = {2'b01, x[22:0]};
    end
    d  = ex - ey;
    my = (d > 8'd24) ? 25'd0 : (my >> d);
    s  = mx + my;
    e  = ex;
    if (s[24]) begin
      s = s >> 1;
      e = e + 8'd1;
    end
    return {e, s[22:0]};
  endfunction

  always @(posedge clk) add_result <= fp_mag_add(add_in1, add_in2);

  function automatic logic [31:0] expected_value(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31], 31'b0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    return {a[31], fp_mag_add(a[30:0], b[30:0])};
  endfunction

  // Every accepted op, in issue order, until it is broadcast; vis = first cycle it may show.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
    int               vis;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  bit   started  = 1'b0;
  int   n_issued = 0;

  always @(posedge clk) begin
    bit   rdy;
    exp_t e;
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else begin
      rdy = (q.size() < DEPTH);
      if (q.size() > 0 && q[0].vis <= cyc && cdb_grant) void'(q.pop_front());
      if (fu_valid && rdy) begin
        e.tag = fu_tag;
        e.val = expected_value(fu_a, fu_b);
        e.vis = cyc + 2;
        q.push_back(e);
        n_issued++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit exp_req;
    if (started) begin
      exp_req = (q.size() > 0) && (q[0].vis <= cyc);
      check("m_cdb_req", {31'b0, cdb_req}, {31'b0, exp_req});
      check("m_fu_ready", {31'b0, fu_ready}, {31'b0, !rst && (q.size() < DEPTH)});
      check("m_add_in1", {1'b0, add_in1}, {1'b0, fu_a[30:0]});
      check("m_add_in2", {1'b0, add_in2}, {1'b0, fu_b[30:0]});
      if (exp_req && cdb_req) begin
        check("m_cdb_tag", {28'b0, cdb_tag}, {28'b0, q[0].tag});
        check("m_cdb_data", cdb_data, q[0].val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_fp(input logic sign);
    logic [7:0] e;
    int         r;
    r = $urandom_range(0, 9);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd254;
    else             e = 8'($urandom_range(1, 253));
    return {sign, e, 23'($urandom)};
  endfunction

  task automatic set_rand_op(input logic [TAG_W-1:0] tag);
    logic s;
    s      = 1'($urandom);
    fu_tag = tag;
    fu_a   = rnd_fp(s);
    fu_b   = rnd_fp(s);
  endtask

  initial begin
    rst = 1'b1; fu_valid = 1'b0; cdb_grant = 1'b0;
    fu_tag = '0; fu_a = '0; fu_b = '0;
    repeat (3) tick();
    @(negedge clk);
    check("ready_in_rst", {31'b0, fu_ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_req", {31'b0, cdb_req}, 32'd0);
    check("rst_tag", {28'b0, cdb_tag}, 32'd0);
    check("rst_data", cdb_data, 32'd0);
    check("rst_ready", {31'b0, fu_ready}, 32'd1);

    // 1.0 + 1.0 with grant held
    tick();
    cdb_grant = 1'b1;
    fu_valid = 1'b1; fu_tag = 4'd3; fu_a = 32'h3F800000; fu_b = 32'h3F800000;
    tick();
    fu_valid = 1'b0;
    @(negedge clk);
    check("one_req_n1", {31'b0, cdb_req}, 32'd0);
    tick();
    @(negedge clk);
    check("one_req_n2", {31'b0, cdb_req}, 32'd1);
    check("one_data", cdb_data, 32'h40000000);
    check("one_tag", {28'b0, cdb_tag}, 32'd3);
    tick();

    // zero bypass
    fu_valid = 1'b1; fu_tag = 4'd5; fu_a = 32'h00000000; fu_b = 32'hC0400000;
    tick();
    fu_valid = 1'b0;
    tick();
    @(negedge clk);
    check("zb_req", {31'b0, cdb_req}, 32'd1);
    check("zb_data", cdb_data, 32'hC0400000);
    check("zb_tag", {28'b0, cdb_tag}, 32'd5);
    tick();

    // backpressure: four back-to-back with no grant, fifth offer held
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu_valid = 1'b1;
      set_rand_op(4'(6 + i));
      tick();
    end
    set_rand_op(4'd10);
    @(negedge clk);
    check("bp_ready", {31'b0, fu_ready}, 32'd0);
    repeat (2) begin
      tick();
      @(negedge clk);
      check("bp_hold", {31'b0, fu_ready}, 32'd0);
    end
    tick();
    fu_valid = 1'b0;
    cdb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_drain_req", {31'b0, cdb_req}, 32'd1);
      check("bp_drain_tag", {28'b0, cdb_tag}, 32'(6 + i));
      tick();
    end
    @(negedge clk);
    check("bp_empty", {31'b0, cdb_req}, 32'd0);

    // three buffered plus one in flight, then simultaneous push and pop
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fu_valid = 1'b1;
      set_rand_op(4'(12 + i));
      tick();
    end
    fu_valid = 1'b0;
    tick();
    fu_valid = 1'b1;
    set_rand_op(4'd15);
    tick();
    fu_valid = 1'b0;
    cdb_grant = 1'b1;
    @(negedge clk);
    check("pp_ready_full", {31'b0, fu_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("pp_ready_after", {31'b0, fu_ready}, 32'd1);
    fu_valid = 1'b1;
    set_rand_op(4'd1);
    tick();
    fu_valid = 1'b0;
    repeat (8) tick();

    // reset with two queued and one in flight
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fu_valid = 1'b1;
      set_rand_op(4'(7 + i));
      tick();
    end
    fu_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", {31'b0, fu_ready}, 32'd0);
    tick();
    rst = 1'b0;
    cdb_grant = 1'b1;
    @(negedge clk);
    check("mid_rst_req", {31'b0, cdb_req}, 32'd0);
    check("mid_rst_tag", {28'b0, cdb_tag}, 32'd0);
    check("mid_rst_data", cdb_data, 32'd0);
    check("mid_rst_ready1", {31'b0, fu_ready}, 32'd1);
    repeat (3) begin
      tick();
      @(negedge clk);
      check("mid_rst_nobcast", {31'b0, cdb_req}, 32'd0);
    end
    tick();

    // randomized order and pointer-wrap run
    for (int i = 0; i < 300; i++) begin
      fu_valid  = ($urandom_range(0, 2) != 0);
      set_rand_op(4'($urandom));
      cdb_grant = 1'($urandom);
      tick();
    end
    fu_valid  = 1'b0;
    cdb_grant = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("final_drain", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
